axi_uartlite_slave: RTL and testbench

//  AXI4 slave register front end for the UART-lite core; consumes the bus produced by the AXI master driver.

---
 rtl/axi_uartlite_slave_if.sv | 53 +++++
 rtl/axi_uartlite_slave.sv | 254 +++++++++++++++++++++++++
 tb/tb_axi_uartlite_slave.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_uartlite_slave_if.sv
// AXI4 bus bundle between the UART-lite register front end and its bus master.
// The slave modport is the register block's view; the master modport is the driver's view.
interface axi_uartlite_slave_if #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8
);
    logic                       awvalid;
    logic                       awready;
    logic [ADDR_WIDTH-1:0]      awaddr;
    logic [BURST_LEN_WIDTH-1:0] awlen;
    logic [2:0]                 awsize;
    logic [1:0]                 awburst;

    logic                       wvalid;
    logic                       wready;
    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_WIDTH/8-1:0]    wstrb;
    logic                       wlast;

    logic                       bvalid;
    logic                       bready;
    logic [1:0]                 bresp;

    logic                       arvalid;
    logic                       arready;
    logic [ADDR_WIDTH-1:0]      araddr;
    logic [BURST_LEN_WIDTH-1:0] arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;

    logic                       rvalid;
    logic                       rready;
    logic [DATA_WIDTH-1:0]      rdata;
    logic [1:0]                 rresp;
    logic                       rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, input awready,
        output wvalid, wdata, wstrb, wlast, input wready,
        input  bvalid, bresp, output bready,
        output arvalid, araddr, arlen, arsize, arburst, input arready,
        input  rvalid, rdata, rresp, rlast, output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, output awready,
        input  wvalid, wdata, wstrb, wlast, output wready,
        output bvalid, bresp, input bready,
        input  arvalid, araddr, arlen, arsize, arburst, output arready,
        output rvalid, rdata, rresp, rlast, input rready
    );
endinterface

// File: rtl/axi_uartlite_slave.sv
// AXI4 register front end for the UART-lite core: RX/TX byte FIFOs, status and control,
// one outstanding burst at a time, valid/ready byte exchange with the serial core.
module axi_uartlite_slave #(
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    axi_uartlite_slave_if.slave  s_axi,
    output logic [7:0]           tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_i,
    input  logic [7:0]           rx_data_i,
    input  logic                 rx_valid_i,
    output logic                 interrupt_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);
    localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, BURST_FIXED = 2'b00;
    localparam logic [1:0] REG_RX = 2'd0, REG_TX = 2'd1, REG_STAT = 2'd2, REG_CTRL = 2'd3;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t                     state_q;
    logic [1:0]                 reg_q, burst_q, bresp_q;
    logic [BURST_LEN_WIDTH-1:0] len_q, beat_q;
    logic                       err_q, awready_q, arready_q, wready_q, bvalid_q, rvalid_q;
    logic                       hold_q, hold_pop_q;
    logic [DATA_WIDTH-1:0]      hold_data_q, rdata_live, stat_word;

    logic [7:0]       tx_mem_q [FIFO_DEPTH];
    logic [7:0]       rx_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] tx_wp_q, tx_rp_q, tx_wp_d, tx_rp_d, rx_wp_q, rx_rp_q, rx_wp_d, rx_rp_d;
    logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic             intr_en_q, overrun_q, interrupt_q;

    logic aw_hs, ar_hs, w_hs, r_hs, b_hs, rlast_w;
    logic tx_push, tx_pop, tx_flush, rx_accept, rx_pop, rx_flush, overrun_set;
    logic ctrl_we, w_err, stat_clr;
    logic rx_nonempty, rx_full, tx_empty, tx_full;
    logic [1:0] next_reg;

    assign aw_hs   = s_axi.awvalid & awready_q;
    assign ar_hs   = s_axi.arvalid & arready_q & ~s_axi.awvalid;
    assign w_hs    = s_axi.wvalid & wready_q;
    assign r_hs    = rvalid_q & s_axi.rready;
    assign b_hs    = bvalid_q & s_axi.bready;
    assign rlast_w = (beat_q == len_q);
    assign next_reg = (burst_q == BURST_FIXED) ? reg_q : reg_q + 2'd1;

    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_full     = (rx_cnt_q == DEPTH);
    assign tx_empty    = (tx_cnt_q == '0);
    assign tx_full     = (tx_cnt_q == DEPTH);
    assign stat_word   = DATA_WIDTH'({overrun_q, intr_en_q, tx_full, tx_empty, rx_full, rx_nonempty});

    always_comb begin
        rdata_live = '0;
        case (reg_q)
            REG_RX:   if (rx_nonempty) rdata_live = DATA_WIDTH'(rx_mem_q[rx_rp_q]);
            REG_STAT: rdata_live = stat_word;
            default:  rdata_live = '0;
        endcase
    end

    always_comb begin
        tx_push  = 1'b0;
        ctrl_we  = 1'b0;
        w_err    = 1'b0;
        rx_pop   = 1'b0;
        stat_clr = 1'b0;
        if (w_hs) begin
            case (reg_q)
                REG_TX: if (s_axi.wstrb[0]) begin
                    if (tx_full) w_err = 1'b1;
                    else         tx_push = 1'b1;
                end
                REG_CTRL: ctrl_we = s_axi.wstrb[0];
                default:  w_err = 1'b1;
            endcase
        end
        // A stalled beat pops only if the byte it first presented was real.
        if (r_hs) begin
            rx_pop   = (reg_q == REG_RX) && (hold_q ? hold_pop_q : rx_nonempty);
            stat_clr = (reg_q == REG_STAT);
        end
    end

    assign tx_flush    = ctrl_we & s_axi.wdata[0];
    assign rx_flush    = ctrl_we & s_axi.wdata[1];
    assign tx_pop      = tx_valid_o & tx_ready_i;
    assign rx_accept   = rx_valid_i & (~rx_full | rx_pop);
    assign overrun_set = rx_valid_i & rx_full & ~rx_pop & ~rx_flush;

    always_comb begin
        tx_wp_d  = tx_wp_q;
        tx_rp_d  = tx_rp_q;
        tx_cnt_d = tx_cnt_q;
        rx_wp_d  = rx_wp_q;
        rx_rp_d  = rx_rp_q;
        rx_cnt_d = rx_cnt_q;
        if (tx_flush) begin
            tx_wp_d  = '0;
            tx_rp_d  = '0;
            tx_cnt_d = '0;
        end else begin
            if (tx_push) tx_wp_d = tx_wp_q + PTR_W'(1);
            if (tx_pop)  tx_rp_d = tx_rp_q + PTR_W'(1);
            tx_cnt_d = tx_cnt_q + CNT_W'(tx_push) - CNT_W'(tx_pop);
        end
        if (rx_flush) begin
            rx_wp_d  = '0;
            rx_rp_d  = '0;
            rx_cnt_d = '0;
        end else begin
            if (rx_accept) rx_wp_d = rx_wp_q + PTR_W'(1);
            if (rx_pop)    rx_rp_d = rx_rp_q + PTR_W'(1);
            rx_cnt_d = rx_cnt_q + CNT_W'(rx_accept) - CNT_W'(rx_pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (tx_push)                tx_mem_q[tx_wp_q] <= s_axi.wdata[7:0];
        if (rx_accept && !rx_flush) rx_mem_q[rx_wp_q] <= rx_data_i;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            tx_wp_q     <= '0;
            tx_rp_q     <= '0;
            tx_cnt_q    <= '0;
            rx_wp_q     <= '0;
            rx_rp_q     <= '0;
            rx_cnt_q    <= '0;
            intr_en_q   <= 1'b0;
            overrun_q   <= 1'b0;
            interrupt_q <= 1'b0;
        end else begin
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            rx_cnt_q <= rx_cnt_d;
            if (ctrl_we) intr_en_q <= s_axi.wdata[4];
            if (overrun_set)   overrun_q <= 1'b1;
            else if (stat_clr) overrun_q <= 1'b0;
            interrupt_q <= intr_en_q & (((rx_cnt_q == '0) && (rx_cnt_d != '0)) ||
                                        ((tx_cnt_q != '0) && (tx_cnt_d == '0)));
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            reg_q       <= '0;
            burst_q     <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            awready_q   <= 1'b0;
            arready_q   <= 1'b0;
            wready_q    <= 1'b0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            hold_q      <= 1'b0;
            hold_pop_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    awready_q <= 1'b1;
                    arready_q <= 1'b1;
                    if (aw_hs) begin
                        state_q   <= WDATA;
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        reg_q     <= s_axi.awaddr[3:2];
                        len_q     <= s_axi.awlen;
                        burst_q   <= s_axi.awburst;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                    end else if (ar_hs) begin
                        state_q   <= RDATA;
                        awready_q <= 1'b0;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        hold_q    <= 1'b0;
                        reg_q     <= s_axi.araddr[3:2];
                        len_q     <= s_axi.arlen;
                        burst_q   <= s_axi.arburst;
                        beat_q    <= '0;
                        err_q     <= 1'b0;
                    end
                end
                WDATA: if (w_hs) begin
                    beat_q <= beat_q + 1'b1;
                    reg_q  <= next_reg;
                    err_q  <= err_q | w_err;
                    if (s_axi.wlast || rlast_w) begin
                        state_q  <= WRESP;
                        wready_q <= 1'b0;
                        bvalid_q <= 1'b1;
                        bresp_q  <= (err_q | w_err) ? RESP_SLVERR : RESP_OKAY;
                    end
                end
                WRESP: if (b_hs) begin
                    state_q   <= IDLE;
                    bvalid_q  <= 1'b0;
                    bresp_q   <= RESP_OKAY;
                    awready_q <= 1'b1;
                    arready_q <= 1'b1;
                end
                RDATA: begin
                    if (r_hs) begin
                        beat_q <= beat_q + 1'b1;
                        reg_q  <= next_reg;
                        hold_q <= 1'b0;
                        if (rlast_w) begin
                            state_q   <= IDLE;
                            rvalid_q  <= 1'b0;
                            awready_q <= 1'b1;
                            arready_q <= 1'b1;
                        end
                    end else if (!hold_q) begin
                        // Freeze the presented beat so a stalled master sees stable data.
                        hold_q      <= 1'b1;
                        hold_data_q <= rdata_live;
                        hold_pop_q  <= rx_nonempty;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi.awready = awready_q;
    assign s_axi.arready = arready_q & ~s_axi.awvalid;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rvalid_q ? (hold_q ? hold_data_q : rdata_live) : '0;
    assign s_axi.rresp   = (rvalid_q && reg_q[0]) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rlast   = rvalid_q & rlast_w;

    assign tx_valid_o  = ~tx_empty;
    assign tx_data_o   = tx_empty ? 8'h00 : tx_mem_q[tx_rp_q];
    assign interrupt_o = interrupt_q;
endmodule

// File: tb/tb_axi_uartlite_slave.sv
// Directed bench for the UART-lite AXI register front end: FIFO traffic, status bits,
// burst addressing, error responses, arbitration and mid-burst reset.
module tb_axi_uartlite_slave;
    logic       aclk;
    logic       aresetn;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready_i;
    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       interrupt_o;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_data [0:31];
    logic [1:0]  rd_resp [0:31];
    logic        rd_last [0:31];
    logic [1:0]  bresp_v;

    axi_uartlite_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BURST_LEN_WIDTH(8)) bus ();

    axi_uartlite_slave #(.DATA_WIDTH(32), .BURST_LEN_WIDTH(8), .FIFO_DEPTH(16)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_axi       (bus.slave),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .rx_data_i   (rx_data_i),
        .rx_valid_i  (rx_valid_i),
        .interrupt_o (interrupt_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        bus.awvalid = 1'b1; bus.awaddr = addr; bus.awlen = len; bus.awsize = 3'd2; bus.awburst = burst;
        #1;
        n = 0;
        while (bus.awready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("awready_wait", 32'(bus.awready), 32'd1);
        tick();
        bus.awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        bus.wvalid = 1'b1; bus.wdata = data; bus.wstrb = strb; bus.wlast = last;
        #1;
        n = 0;
        while (bus.wready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("wready_wait", 32'(bus.wready), 32'd1);
        tick();
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
    endtask

    task automatic b_recv(output logic [1:0] resp);
        int n;
        bus.bready = 1'b1;
        #1;
        n = 0;
        while (bus.bvalid !== 1'b1 && n < 50) begin tick(); n++; end
        chk("bvalid_wait", 32'(bus.bvalid), 32'd1);
        resp = bus.bresp;
        tick();
        bus.bready = 1'b0;
        $display("write response bresp=%0d", resp);
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
        int n;
        bus.arvalid = 1'b1; bus.araddr = addr; bus.arlen = len; bus.arsize = 3'd2; bus.arburst = burst;
        #1;
        n = 0;
        while (bus.arready !== 1'b1 && n < 50) begin tick(); n++; end
        chk("arready_wait", 32'(bus.arready), 32'd1);
        tick();
        bus.arvalid = 1'b0;
    endtask

    task automatic r_recv(input int beats);
        int n;
        bus.rready = 1'b1;
        for (int b = 0; b < beats; b++) begin
            #1;
            n = 0;
            while (bus.rvalid !== 1'b1 && n < 50) begin tick(); n++; end
            chk("rvalid_wait", 32'(bus.rvalid), 32'd1);
            rd_data[b] = bus.rdata; rd_resp[b] = bus.rresp; rd_last[b] = bus.rlast;
            tick();
            $display("read beat %0d rdata=0x%0h rresp=%0d rlast=%0d", b, rd_data[b], rd_resp[b], rd_last[b]);
        end
        bus.rready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0; tx_ready_i = 1'b0; rx_data_i = 8'h00; rx_valid_i = 1'b0;
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
        bus.rready = 1'b0;
        repeat (3) tick();
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_interrupt", 32'(interrupt_o), 32'd0);
        aresetn = 1'b1;
        repeat (2) tick();
        chk("idle_awready", 32'(bus.awready), 32'd1);

        // single TX write, consumed immediately by the transmitter
        tx_ready_i = 1'b1;
        aw_send(32'h4, 8'd0, 2'b01);
        w_send(32'h41, 4'hF, 1'b1);
        chk("t1_tx_valid", 32'(tx_valid_o), 32'd1);
        chk("t1_tx_data", 32'(tx_data_o), 32'h41);
        b_recv(bresp_v);
        chk("t1_bresp", 32'(bresp_v), 32'd0);
        chk("t1_tx_drained", 32'(tx_valid_o), 32'd0);
        tx_ready_i = 1'b0;

        // three RX bytes, FIXED read of four beats
        rx_valid_i = 1'b1;
        rx_data_i = 8'h10; tick();
        rx_data_i = 8'h20; tick();
        rx_data_i = 8'h30; tick();
        rx_valid_i = 1'b0;
        ar_send(32'h0, 8'd3, 2'b00);
        r_recv(4);
        chk("t2_rdata0", rd_data[0], 32'h10);
        chk("t2_rdata1", rd_data[1], 32'h20);
        chk("t2_rdata2", rd_data[2], 32'h30);
        chk("t2_rdata3_empty", rd_data[3], 32'h0);
        chk("t2_rlast0", 32'(rd_last[0]), 32'd0);
        chk("t2_rlast3", 32'(rd_last[3]), 32'd1);
        chk("t2_rresp", 32'(rd_resp[0] | rd_resp[1] | rd_resp[2] | rd_resp[3]), 32'd0);

        // 17-beat FIXED write into a 16-deep TX FIFO with the transmitter stalled
        aw_send(32'h4, 8'd16, 2'b00);
        for (int i = 0; i < 17; i++) w_send(32'h50 + 32'(i), 4'hF, i == 16);
        b_recv(bresp_v);
        chk("t3_bresp", 32'(bresp_v), 32'd2);
        chk("t3_tx_head", 32'(tx_data_o), 32'h50);
        ar_send(32'h8, 8'd0, 2'b01);
        r_recv(1);
        chk("t3_stat", rd_data[0], 32'h08);
        tx_ready_i = 1'b1;
        repeat (20) tick();
        chk("t3_tx_drained", 32'(tx_valid_o), 32'd0);
        tx_ready_i = 1'b0;

        // RX overrun, STAT read clears it; INCR burst wraps into write-only CTRL
        rx_valid_i = 1'b1;
        for (int i = 0; i < 17; i++) begin rx_data_i = 8'h80 + 8'(i); tick(); end
        rx_valid_i = 1'b0;
        ar_send(32'h8, 8'd0, 2'b01);
        r_recv(1);
        chk("t4_stat_overrun", rd_data[0], 32'h27);
        ar_send(32'h8, 8'd1, 2'b01);
        r_recv(2);
        chk("t4_stat_cleared", rd_data[0], 32'h07);
        chk("t4_stat_rresp", 32'(rd_resp[0]), 32'd0);
        chk("t4_ctrl_rdata", rd_data[1], 32'h0);
        chk("t4_ctrl_rresp", 32'(rd_resp[1]), 32'd2);
        chk("t4_ctrl_rlast", 32'(rd_last[1]), 32'd1);
        ar_send(32'h0, 8'd0, 2'b01);
        tick(); tick();
        chk("t4_stall_rvalid", 32'(bus.rvalid), 32'd1);
        chk("t4_stall_rdata", bus.rdata, 32'h80);
        r_recv(1);
        chk("t4_rx_head", rd_data[0], 32'h80);

        // flush both FIFOs and enable interrupts, then an RX byte raises a pulse
        aw_send(32'hC, 8'd0, 2'b01);
        w_send(32'h13, 4'hF, 1'b1);
        b_recv(bresp_v);
        chk("t5_ctrl_bresp", 32'(bresp_v), 32'd0);
        ar_send(32'h8, 8'd0, 2'b01);
        r_recv(1);
        chk("t5_stat", rd_data[0], 32'h14);
        chk("t5_no_intr", 32'(interrupt_o), 32'd0);
        rx_valid_i = 1'b1; rx_data_i = 8'hA5;
        tick();
        rx_valid_i = 1'b0;
        chk("t5_intr_pulse", 32'(interrupt_o), 32'd1);
        tick();
        chk("t5_intr_end", 32'(interrupt_o), 32'd0);

        // simultaneous AW and AR: the write is served first
        bus.awvalid = 1'b1; bus.awaddr = 32'h4; bus.awlen = 8'd0; bus.awsize = 3'd2; bus.awburst = 2'b01;
        bus.arvalid = 1'b1; bus.araddr = 32'h8; bus.arlen = 8'd0; bus.arsize = 3'd2; bus.arburst = 2'b01;
        #1;
        chk("t6_awready", 32'(bus.awready), 32'd1);
        chk("t6_arready_blocked", 32'(bus.arready), 32'd0);
        tick();
        bus.awvalid = 1'b0;
        #1;
        chk("t6_arready_wdata", 32'(bus.arready), 32'd0);
        w_send(32'h66, 4'hF, 1'b1);
        b_recv(bresp_v);
        chk("t6_bresp", 32'(bresp_v), 32'd0);
        ar_send(32'h8, 8'd0, 2'b01);
        r_recv(1);
        chk("t6_stat_after_write", rd_data[0], 32'h11);

        // write to read-only STAT is rejected
        aw_send(32'h8, 8'd0, 2'b01);
        w_send(32'hFF, 4'hF, 1'b1);
        b_recv(bresp_v);
        chk("t6_stat_write_bresp", 32'(bresp_v), 32'd2);

        // reset in the middle of a write burst abandons it
        aw_send(32'h4, 8'd3, 2'b01);
        w_send(32'h77, 4'hF, 1'b0);
        aresetn = 1'b0;
        tick();
        chk("t6_rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("t6_rst_wready", 32'(bus.wready), 32'd0);
        chk("t6_rst_tx_valid", 32'(tx_valid_o), 32'd0);
        aresetn = 1'b1;
        bus.bready = 1'b1;
        tick(); tick();
        chk("t6_post_rst_awready", 32'(bus.awready), 32'd1);
        chk("t6_post_rst_bvalid", 32'(bus.bvalid), 32'd0);
        bus.bready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
